// File: rtl/ofdm_pilot_equalizer.sv
// OFDM channel equalizer: learns H[k] from an all-ones training symbol, then
// outputs Y[k]*conj(H[k]) scaled by SHIFT and saturated to 16 bits per component.
module ofdm_pilot_equalizer #(
  parameter int NFFT  = 64,
  parameter int NSYM  = 14,
  parameter int SHIFT = 14,
  parameter int AW    = $clog2(NFFT)
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic        asi_in0_ready,
  output logic [31:0] aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
  output logic        est_valid,
  output logic        sat_flag
);

  localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1;

  typedef enum logic {ST_TRAIN, ST_DATA} state_t;

  state_t                r_state, w_stateNext;
  logic [AW-1:0]         r_k, w_kNext;
  logic [SW-1:0]         r_sym, w_symNext;
  logic                  r_est, r_sat;
  logic                  w_estSet, w_trainWr, w_dataRd;
  logic                  w_en, w_accept, w_lastK, w_lastSym;

  logic [31:0]           r_hMem [NFFT];
  logic                  r_s1Valid, r_pValid, r_outValid;
  logic [31:0]           r_s1Y, r_s1H, r_outData;
  logic signed [32:0]    r_pRe, r_pIm;

  logic signed [15:0]    w_yi, w_yq, w_hi, w_hq;
  logic signed [31:0]    w_pA, w_pB, w_pC, w_pD;
  logic signed [32:0]    w_re, w_im, w_reSh, w_imSh;
  logic [16:0]           w_reSat, w_imSat;

  // Returns {clamped, value} for a 33-bit signed input squeezed into 16 bits.
  function automatic logic [16:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       return {1'b1, 16'h7FFF};
    else if (v < -33'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

  assign w_en          = !r_outValid || aso_out0_ready;
  assign asi_in0_ready = (r_state == ST_TRAIN) ? 1'b1 : w_en;
  assign w_accept      = asi_in0_valid && asi_in0_ready;
  assign w_lastK       = (r_k == AW'(NFFT - 1));
  assign w_lastSym     = (r_sym == SW'(NSYM - 1));

  always_comb begin
    w_stateNext = r_state;
    w_kNext     = r_k;
    w_symNext   = r_sym;
    w_estSet    = 1'b0;
    w_trainWr   = 1'b0;
    w_dataRd    = 1'b0;
    if (w_accept) begin
      w_kNext = r_k + AW'(1);
      case (r_state)
        ST_TRAIN: begin
          w_trainWr = 1'b1;
          if (w_lastK) begin
            w_symNext   = '0;
            w_estSet    = 1'b1;
            w_stateNext = ST_DATA;
          end
        end
        ST_DATA: begin
          w_dataRd = 1'b1;
          if (w_lastK) begin
            if (w_lastSym) begin
              w_symNext   = '0;
              w_stateNext = ST_TRAIN;
            end else begin
              w_symNext = r_sym + SW'(1);
            end
          end
        end
        default: w_stateNext = ST_TRAIN;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_TRAIN;
      r_k     <= '0;
      r_sym   <= '0;
      r_est   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_k     <= w_kNext;
      r_sym   <= w_symNext;
      if (w_estSet) r_est <= 1'b1;
    end
  end

  // Channel store and datapath registers carry no reset so they map onto RAM/DSP.
  always_ff @(posedge clk_clk) begin
    if (w_trainWr) r_hMem[r_k] <= asi_in0_data;
    if (w_en && w_dataRd) begin
      r_s1Y <= asi_in0_data;
      r_s1H <= r_hMem[r_k];
    end
    if (w_en) begin
      r_pRe <= w_re;
      r_pIm <= w_im;
    end
  end

  assign w_yi = r_s1Y[31:16];
  assign w_yq = r_s1Y[15:0];
  assign w_hi = r_s1H[31:16];
  assign w_hq = r_s1H[15:0];
  assign w_pA = w_yi * w_hi;
  assign w_pB = w_yq * w_hq;
  assign w_pC = w_yq * w_hi;
  assign w_pD = w_yi * w_hq;
  assign w_re = {w_pA[31], w_pA} + {w_pB[31], w_pB};
  assign w_im = {w_pC[31], w_pC} - {w_pD[31], w_pD};

  assign w_reSh  = r_pRe >>> SHIFT;
  assign w_imSh  = r_pIm >>> SHIFT;
  assign w_reSat = sat16(w_reSh);
  assign w_imSat = sat16(w_imSh);

  // All pipeline stages advance together on w_en so a stall never drops or repeats a sample.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1Valid  <= 1'b0;
      r_pValid   <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_sat      <= 1'b0;
    end else if (w_en) begin
      r_s1Valid  <= w_dataRd;
      r_pValid   <= r_s1Valid;
      r_outValid <= r_pValid;
      if (r_pValid) begin
        r_outData <= {w_reSat[15:0], w_imSat[15:0]};
        if (w_reSat[16] || w_imSat[16]) r_sat <= 1'b1;
      end
    end
  end

  assign aso_out0_data  = r_outData;
  assign aso_out0_valid = r_outValid;
  assign est_valid      = r_est;
  assign sat_flag       = r_sat;

endmodule
